// File: rtl/csr_file_if.sv
// CSR-file bus: CSR access port, trap/mret control, interrupt lines and the
// redirect/status outputs consumed by the commit stage and MMU.
interface csr_file_if #(
    parameter int unsigned XLEN = 64
);
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            trap_valid;
    logic            trap_is_irq;
    logic [5:0]      trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            mret_valid;
    logic            retire_valid;
    logic            ext_irq;
    logic            timer_irq;
    logic            sw_irq;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            irq_pending;
    logic [5:0]      irq_cause;
    logic [1:0]      priv_mode;
    logic [XLEN-1:0] satp_out;

    modport master (
        output csr_addr, csr_op, csr_wdata, trap_valid, trap_is_irq, trap_cause, trap_pc,
               trap_tval, mret_valid, retire_valid, ext_irq, timer_irq, sw_irq,
        input  csr_rdata, csr_illegal, redirect_valid, redirect_pc, irq_pending, irq_cause,
               priv_mode, satp_out
    );

    modport slave (
        input  csr_addr, csr_op, csr_wdata, trap_valid, trap_is_irq, trap_cause, trap_pc,
               trap_tval, mret_valid, retire_valid, ext_irq, timer_irq, sw_irq,
        output csr_rdata, csr_illegal, redirect_valid, redirect_pc, irq_pending, irq_cause,
               priv_mode, satp_out
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational checked reads, registered RW/RS/RC updates,
// trap entry / mret, mip sampling and the mcycle/minstret counters.
module csr_file #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input logic       clk,
    input logic       reset,
    csr_file_if.slave bus
);
    localparam logic [11:0] AddrSatp      = 12'h180;
    localparam logic [11:0] AddrMstatus   = 12'h300;
    localparam logic [11:0] AddrMie       = 12'h304;
    localparam logic [11:0] AddrMtvec     = 12'h305;
    localparam logic [11:0] AddrMscratch  = 12'h340;
    localparam logic [11:0] AddrMepc      = 12'h341;
    localparam logic [11:0] AddrMcause    = 12'h342;
    localparam logic [11:0] AddrMtval     = 12'h343;
    localparam logic [11:0] AddrMip       = 12'h344;
    localparam logic [11:0] AddrMcycle    = 12'hB00;
    localparam logic [11:0] AddrMinstret  = 12'hB02;
    localparam logic [11:0] AddrMcycleh   = 12'hB80;
    localparam logic [11:0] AddrMinstreth = 12'hB82;
    localparam logic [11:0] AddrMhartid   = 12'hF14;
    localparam bit          Rv32          = (XLEN == 32);
    // On RV32 a write to the low counter half must keep the high half.
    localparam logic [63:0] KeepOnLowWr   = Rv32 ? 64'hFFFF_FFFF_0000_0000 : 64'h0;

    // Interrupt bit vectors are packed as {MEI, MTI, MSI}.
    logic [1:0]      priv_q, priv_d;
    logic            st_mie_q, st_mie_d;
    logic            st_mpie_q, st_mpie_d;
    logic [1:0]      st_mpp_q, st_mpp_d;
    logic [2:0]      mie_q, mie_d;
    logic [2:0]      mip_q, mip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] satp_q, satp_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] mtvec_base;
    logic [XLEN-1:0] trap_target;
    logic [2:0]      irq_vec;
    logic            implemented;
    logic            wr_attempt;
    logic            illegal;
    logic            csr_we;
    logic            satp_mode_ok;
    logic            irq_enabled;

    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (bus.csr_addr)
            AddrSatp:      old_val = satp_q;
            AddrMstatus: begin
                old_val[3]     = st_mie_q;
                old_val[7]     = st_mpie_q;
                old_val[12:11] = st_mpp_q;
            end
            AddrMie: begin
                old_val[3]  = mie_q[0];
                old_val[7]  = mie_q[1];
                old_val[11] = mie_q[2];
            end
            AddrMtvec:     old_val = mtvec_q;
            AddrMscratch:  old_val = mscratch_q;
            AddrMepc:      old_val = mepc_q;
            AddrMcause:    old_val = mcause_q;
            AddrMtval:     old_val = mtval_q;
            AddrMip: begin
                old_val[3]  = mip_q[0];
                old_val[7]  = mip_q[1];
                old_val[11] = mip_q[2];
            end
            AddrMcycle:    old_val = mcycle_q[XLEN-1:0];
            AddrMinstret:  old_val = minstret_q[XLEN-1:0];
            AddrMcycleh: begin
                if (Rv32) old_val = XLEN'(mcycle_q >> 32);
                else      implemented = 1'b0;
            end
            AddrMinstreth: begin
                if (Rv32) old_val = XLEN'(minstret_q >> 32);
                else      implemented = 1'b0;
            end
            AddrMhartid:   old_val = '0;
            default:       implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read and never counts as a write.
    assign wr_attempt = (bus.csr_op == 2'b01) || (bus.csr_op[1] && (|bus.csr_wdata));
    assign illegal    = ((bus.csr_op != 2'b00) && !implemented)
                      || (bus.csr_addr[9:8] > priv_q)
                      || (wr_attempt && ((bus.csr_addr[11:10] == 2'b11)
                                         || (bus.csr_addr == AddrMip)));
    assign csr_we     = wr_attempt && !illegal && !bus.trap_valid && !bus.mret_valid;

    always_comb begin
        case (bus.csr_op)
            2'b01:   new_val = bus.csr_wdata;
            2'b10:   new_val = old_val | bus.csr_wdata;
            2'b11:   new_val = old_val & ~bus.csr_wdata;
            default: new_val = old_val;
        endcase
    end

    assign satp_mode_ok = Rv32 || (new_val[XLEN-1 -: 4] == 4'h0)
                               || (new_val[XLEN-1 -: 4] == 4'h8);

    always_comb begin
        priv_d     = priv_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        st_mpp_d   = st_mpp_q;
        mie_d      = mie_q;
        mip_d      = {bus.ext_irq, bus.timer_irq, bus.sw_irq};
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        satp_d     = satp_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.retire_valid};

        if (bus.trap_valid) begin
            mepc_d             = {bus.trap_pc[XLEN-1:2], 2'b00};
            mcause_d           = '0;
            mcause_d[XLEN-1]   = bus.trap_is_irq;
            mcause_d[5:0]      = bus.trap_cause;
            mtval_d            = bus.trap_tval;
            st_mpie_d          = st_mie_q;
            st_mie_d           = 1'b0;
            st_mpp_d           = priv_q;
            priv_d             = 2'b11;
        end else if (bus.mret_valid) begin
            priv_d    = st_mpp_q;
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
            st_mpp_d  = 2'b00;
        end else if (csr_we) begin
            case (bus.csr_addr)
                AddrSatp:      if (satp_mode_ok) satp_d = new_val;
                AddrMstatus: begin
                    st_mie_d  = new_val[3];
                    st_mpie_d = new_val[7];
                    st_mpp_d  = (new_val[12:11] == 2'b10) ? 2'b00 : new_val[12:11];
                end
                AddrMie:       mie_d = {new_val[11], new_val[7], new_val[3]};
                AddrMtvec:     mtvec_d = {new_val[XLEN-1:2],
                                          new_val[1] ? 2'b00 : new_val[1:0]};
                AddrMscratch:  mscratch_d = new_val;
                AddrMepc:      mepc_d = {new_val[XLEN-1:2], 2'b00};
                AddrMcause:    mcause_d = new_val;
                AddrMtval:     mtval_d = new_val;
                AddrMcycle:    mcycle_d = (mcycle_q & KeepOnLowWr) | 64'(new_val);
                AddrMinstret:  minstret_d = (minstret_q & KeepOnLowWr) | 64'(new_val);
                AddrMcycleh:   mcycle_d = {new_val[31:0], mcycle_q[31:0]};
                AddrMinstreth: minstret_d = {new_val[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            priv_q     <= 2'b11;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            st_mpp_q   <= 2'b00;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            satp_q     <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            priv_q     <= priv_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            st_mpp_q   <= st_mpp_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            satp_q     <= satp_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target = mtvec_base
                       + ((bus.trap_is_irq && (mtvec_q[1:0] == 2'b01))
                          ? XLEN'({bus.trap_cause, 2'b00}) : '0);

    assign irq_vec     = mip_q & mie_q;
    assign irq_enabled = st_mie_q || (priv_q != 2'b11);

    always_comb begin
        bus.irq_cause = 6'd0;
        if (irq_enabled) begin
            if (irq_vec[2])      bus.irq_cause = 6'd11;
            else if (irq_vec[0]) bus.irq_cause = 6'd3;
            else if (irq_vec[1]) bus.irq_cause = 6'd7;
        end
    end

    assign bus.csr_rdata      = illegal ? '0 : old_val;
    assign bus.csr_illegal    = illegal;
    assign bus.redirect_valid = bus.trap_valid | bus.mret_valid;
    assign bus.redirect_pc    = bus.trap_valid ? trap_target : mepc_q;
    assign bus.irq_pending    = irq_enabled && (|irq_vec);
    assign bus.priv_mode      = priv_q;
    assign bus.satp_out       = satp_q;
endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file (XLEN=64): directed scenarios plus a
// randomized run against an address-indexed architectural model.
module tb_csr_file;
    localparam int unsigned XLEN = 64;
    localparam logic [63:0] MTV  = 64'h0000_0000_0000_0200;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    csr_file_if #(.XLEN(XLEN)) bus ();

    csr_file #(.XLEN(XLEN), .MTVEC_RESET(MTV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Architectural model: one 64-bit word per CSR address plus privilege.
    logic [63:0] m_csr [0:4095];
    logic [1:0]  m_priv;

    function automatic bit m_impl(input logic [11:0] a);
        return a inside {12'h180, 12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hB00, 12'hB02, 12'hF14};
    endfunction

    function automatic bit m_writes(input logic [1:0] op, input logic [63:0] wd);
        return (op == 2'd1) || (op >= 2'd2 && wd != 64'd0);
    endfunction

    function automatic bit m_illegal(input logic [11:0] a, input logic [1:0] op,
                                     input logic [63:0] wd);
        return ((op != 2'd0) && !m_impl(a)) || (a[9:8] > m_priv)
            || (m_writes(op, wd) && (a[11:10] == 2'b11 || a == 12'h344));
    endfunction

    function automatic logic [5:0] m_irq_cause();
        logic [63:0] pend;
        logic [63:0] st;
        pend = m_csr[12'h344] & m_csr[12'h304];
        st   = m_csr[12'h300];
        if (!(st[3] || m_priv != 2'b11)) return 6'd0;
        if (pend[11]) return 6'd11;
        if (pend[3])  return 6'd3;
        if (pend[7])  return 6'd7;
        return 6'd0;
    endfunction

    function automatic logic [63:0] m_redirect();
        logic [63:0] tv;
        tv = m_csr[12'h305];
        if (bus.trap_valid)
            return (tv & ~64'h3)
                 + ((bus.trap_is_irq && tv[1:0] == 2'b01) ? 64'(bus.trap_cause) * 4 : 64'd0);
        return m_csr[12'h341];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4096; i++) m_csr[i] = 64'd0;
        m_csr[12'h305] = MTV;
        m_priv = 2'b11;
    endtask

    task automatic model_update();
        logic [11:0] a;
        logic [63:0] old, nv, cyc, ins, st;
        logic        ill, wr;
        a   = bus.csr_addr;
        old = m_csr[a];
        ill = m_illegal(a, bus.csr_op, bus.csr_wdata);
        wr  = m_writes(bus.csr_op, bus.csr_wdata);
        cyc = m_csr[12'hB00] + 64'd1;
        ins = m_csr[12'hB02] + (bus.retire_valid ? 64'd1 : 64'd0);
        st  = m_csr[12'h300];
        if (bus.trap_valid) begin
            m_csr[12'h341] = bus.trap_pc & ~64'h3;
            m_csr[12'h342] = (bus.trap_is_irq ? 64'h8000_0000_0000_0000 : 64'd0)
                           + 64'(bus.trap_cause);
            m_csr[12'h343] = bus.trap_tval;
            m_csr[12'h300] = (st[3] ? 64'h80 : 64'h0) + 64'(m_priv) * 64'h800;
            m_priv = 2'b11;
        end else if (bus.mret_valid) begin
            m_priv = st[12:11];
            m_csr[12'h300] = (st[7] ? 64'h8 : 64'h0) + 64'h80;
        end else if (wr && !ill) begin
            case (bus.csr_op)
                2'd1:    nv = bus.csr_wdata;
                2'd2:    nv = old | bus.csr_wdata;
                default: nv = old & ~bus.csr_wdata;
            endcase
            case (a)
                12'h180: if (nv[63:60] == 4'h0 || nv[63:60] == 4'h8) m_csr[a] = nv;
                12'h300: begin
                    nv = nv & 64'h1888;
                    if (nv[12:11] == 2'b10) nv[12:11] = 2'b00;
                    m_csr[a] = nv;
                end
                12'h304: m_csr[a] = nv & 64'h888;
                12'h305: begin
                    if (nv[1:0] >= 2'd2) nv[1:0] = 2'd0;
                    m_csr[a] = nv;
                end
                12'h341: m_csr[a] = nv & ~64'h3;
                12'hB00: cyc = nv;
                12'hB02: ins = nv;
                default: m_csr[a] = nv;
            endcase
        end
        m_csr[12'hB00] = cyc;
        m_csr[12'hB02] = ins;
        m_csr[12'h344] = (bus.ext_irq ? 64'h800 : 64'h0) | (bus.timer_irq ? 64'h80 : 64'h0)
                       | (bus.sw_irq ? 64'h8 : 64'h0);
    endtask

    task automatic idle();
        bus.csr_addr = 12'h0; bus.csr_op = 2'd0; bus.csr_wdata = 64'd0;
        bus.trap_valid = 1'b0; bus.trap_is_irq = 1'b0; bus.trap_cause = 6'd0;
        bus.trap_pc = 64'd0; bus.trap_tval = 64'd0; bus.mret_valid = 1'b0;
        bus.retire_valid = 1'b0; bus.ext_irq = 1'b0; bus.timer_irq = 1'b0; bus.sw_irq = 1'b0;
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd);
        bus.csr_addr = a; bus.csr_op = op; bus.csr_wdata = wd;
        #1;
    endtask

    // One clock: advance the model with the inputs currently applied, then the DUT.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        bus.trap_valid = 1'b0; bus.mret_valid = 1'b0; bus.retire_valid = 1'b0;
        bus.csr_op = 2'd0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (5) step();
        set_csr(12'hB00, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'd5) begin n_err++; $display("FAIL reset_mcycle: got %h want 5", bus.csr_rdata); end
        n_cmp++; if (bus.priv_mode !== 2'b11) begin n_err++; $display("FAIL reset_priv: got %b want 11", bus.priv_mode); end
        n_cmp++; if (bus.satp_out !== 64'd0 || bus.irq_pending !== 1'b0) begin n_err++; $display("FAIL reset_outs: satp %h irq %b want 0/0", bus.satp_out, bus.irq_pending); end
        set_csr(12'h305, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== MTV) begin n_err++; $display("FAIL reset_mtvec: got %h want %h", bus.csr_rdata, MTV); end
        set_csr(12'h340, 2'd1, 64'h1234);
        step(); step();
        reset = 1'b1;
        #2;
        set_csr(12'h340, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'd0) begin n_err++; $display("FAIL async_reset_mscratch: got %h want 0", bus.csr_rdata); end
        set_csr(12'hB00, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'd0) begin n_err++; $display("FAIL async_reset_mcycle: got %h want 0", bus.csr_rdata); end
        reset = 1'b0;
        model_reset();
        step();
        set_csr(12'hB00, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'd1) begin n_err++; $display("FAIL first_inc: got %h want 1", bus.csr_rdata); end
    endtask

    task automatic test_mstatus();
        set_csr(12'h300, 2'd1, 64'hFFFF_FFFF); step();
        set_csr(12'h300, 2'd2, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h1888) begin n_err++; $display("FAIL mstatus_rw: got %h want 1888", bus.csr_rdata); end
        set_csr(12'h300, 2'd3, 64'h8); step();
        set_csr(12'h300, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h1880) begin n_err++; $display("FAIL mstatus_rc: got %h want 1880", bus.csr_rdata); end
        set_csr(12'h300, 2'd2, 64'h8); step();
        set_csr(12'h300, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h1888) begin n_err++; $display("FAIL mstatus_rs: got %h want 1888", bus.csr_rdata); end
        set_csr(12'h300, 2'd1, 64'h1000); step();
        set_csr(12'h300, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h0) begin n_err++; $display("FAIL mstatus_mpp10: got %h want 0", bus.csr_rdata); end
        set_csr(12'h304, 2'd1, '1); step();
        set_csr(12'h304, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h888) begin n_err++; $display("FAIL mie_mask: got %h want 888", bus.csr_rdata); end
    endtask

    task automatic test_irq_trap();
        set_csr(12'h305, 2'd1, 64'h1001); step();
        set_csr(12'h304, 2'd1, 64'h80); step();
        set_csr(12'h300, 2'd1, 64'h8); step();
        bus.timer_irq = 1'b1;
        set_csr(12'h0, 2'd0, 64'd0);
        n_cmp++; if (bus.irq_pending !== 1'b0) begin n_err++; $display("FAIL mip_lag: got %b want 0", bus.irq_pending); end
        step();
        n_cmp++; if (bus.irq_pending !== 1'b1 || bus.irq_cause !== 6'd7) begin n_err++; $display("FAIL irq_timer: got %b/%0d want 1/7", bus.irq_pending, bus.irq_cause); end
        bus.trap_valid = 1'b1; bus.trap_is_irq = 1'b1; bus.trap_cause = 6'd7; bus.trap_pc = 64'h400;
        #1;
        n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 64'h101C) begin n_err++; $display("FAIL vec_redirect: got %b/%h want 1/101c", bus.redirect_valid, bus.redirect_pc); end
        step();
        set_csr(12'h300, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h1880) begin n_err++; $display("FAIL trap_mstatus: got %h want 1880", bus.csr_rdata); end
        n_cmp++; if (bus.irq_pending !== 1'b0 || bus.irq_cause !== 6'd0) begin n_err++; $display("FAIL irq_masked: got %b/%0d want 0/0", bus.irq_pending, bus.irq_cause); end
        set_csr(12'h342, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h8000_0000_0000_0007) begin n_err++; $display("FAIL trap_mcause: got %h want 8000000000000007", bus.csr_rdata); end
        bus.trap_valid = 1'b1; bus.trap_is_irq = 1'b0; bus.trap_cause = 6'd2; bus.trap_pc = 64'h404;
        #1;
        n_cmp++; if (bus.redirect_pc !== 64'h1000) begin n_err++; $display("FAIL exc_redirect: got %h want 1000", bus.redirect_pc); end
        step();
        bus.timer_irq = 1'b0;
    endtask

    task automatic test_trap_mret();
        set_csr(12'h300, 2'd1, 64'h0); step();
        bus.mret_valid = 1'b1;
        #1;
        n_cmp++; if (bus.redirect_pc !== 64'h404) begin n_err++; $display("FAIL mret_redirect0: got %h want 404", bus.redirect_pc); end
        step();
        n_cmp++; if (bus.priv_mode !== 2'b00) begin n_err++; $display("FAIL mret_to_user: got %b want 00", bus.priv_mode); end
        bus.trap_valid = 1'b1; bus.trap_is_irq = 1'b0; bus.trap_cause = 6'd2;
        bus.trap_pc = 64'h8000_0042; bus.trap_tval = 64'hDEAD;
        #1; step();
        n_cmp++; if (bus.priv_mode !== 2'b11) begin n_err++; $display("FAIL trap_priv: got %b want 11", bus.priv_mode); end
        set_csr(12'h341, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h8000_0040) begin n_err++; $display("FAIL trap_mepc: got %h want 80000040", bus.csr_rdata); end
        set_csr(12'h343, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'hDEAD) begin n_err++; $display("FAIL trap_mtval: got %h want dead", bus.csr_rdata); end
        set_csr(12'h300, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h0) begin n_err++; $display("FAIL trap_mpp_user: got %h want 0", bus.csr_rdata); end
        bus.mret_valid = 1'b1;
        #1;
        n_cmp++; if (bus.redirect_pc !== 64'h8000_0040) begin n_err++; $display("FAIL mret_redirect: got %h want 80000040", bus.redirect_pc); end
        step();
        n_cmp++; if (bus.priv_mode !== 2'b00) begin n_err++; $display("FAIL mret_priv: got %b want 00", bus.priv_mode); end
    endtask

    task automatic test_illegal();
        set_csr(12'h300, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_illegal !== 1'b1 || bus.csr_rdata !== 64'd0) begin n_err++; $display("FAIL user_mstatus: got %b/%h want 1/0", bus.csr_illegal, bus.csr_rdata); end
        set_csr(12'h001, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_illegal !== 1'b0) begin n_err++; $display("FAIL unimpl_noop: got %b want 0", bus.csr_illegal); end
        set_csr(12'h001, 2'd1, 64'd5);
        n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_err++; $display("FAIL unimpl_write: got %b want 1", bus.csr_illegal); end
        bus.trap_valid = 1'b1; bus.trap_cause = 6'd3; bus.trap_pc = 64'h100;
        set_csr(12'h0, 2'd0, 64'd0); step();
        set_csr(12'hF14, 2'd1, 64'd5);
        n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_err++; $display("FAIL ro_write: got %b want 1", bus.csr_illegal); end
        step();
        set_csr(12'hF14, 2'd2, 64'd0);
        n_cmp++; if (bus.csr_illegal !== 1'b0 || bus.csr_rdata !== 64'd0) begin n_err++; $display("FAIL ro_rs0: got %b/%h want 0/0", bus.csr_illegal, bus.csr_rdata); end
        set_csr(12'h344, 2'd1, 64'h8);
        n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_err++; $display("FAIL mip_write: got %b want 1", bus.csr_illegal); end
        set_csr(12'hB80, 2'd2, 64'd1);
        n_cmp++; if (bus.csr_illegal !== 1'b1) begin n_err++; $display("FAIL mcycleh_rv64: got %b want 1", bus.csr_illegal); end
        set_csr(12'h180, 2'd1, 64'h5000_0000_0000_1234); step();
        n_cmp++; if (bus.satp_out !== 64'd0) begin n_err++; $display("FAIL satp_mode5: got %h want 0", bus.satp_out); end
        set_csr(12'h180, 2'd1, 64'h8000_0000_0000_1234); step();
        n_cmp++; if (bus.satp_out !== 64'h8000_0000_0000_1234) begin n_err++; $display("FAIL satp_mode8: got %h want 8000000000001234", bus.satp_out); end
        set_csr(12'h305, 2'd1, 64'h2003); step();
        set_csr(12'h305, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h2000) begin n_err++; $display("FAIL mtvec_mode3: got %h want 2000", bus.csr_rdata); end
    endtask

    task automatic test_priority();
        bus.trap_valid = 1'b1; bus.mret_valid = 1'b1; bus.trap_is_irq = 1'b0;
        bus.trap_cause = 6'd5; bus.trap_pc = 64'h3000;
        set_csr(12'h340, 2'd1, 64'hABCD);
        n_cmp++; if (bus.redirect_pc !== 64'h2000) begin n_err++; $display("FAIL trap_over_mret: got %h want 2000", bus.redirect_pc); end
        step();
        set_csr(12'h341, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h3000 || bus.priv_mode !== 2'b11) begin n_err++; $display("FAIL trap_won: got %h/%b want 3000/11", bus.csr_rdata, bus.priv_mode); end
        set_csr(12'h340, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'd0) begin n_err++; $display("FAIL write_dropped_trap: got %h want 0", bus.csr_rdata); end
        bus.mret_valid = 1'b1;
        set_csr(12'h340, 2'd1, 64'h55); step();
        set_csr(12'h340, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'd0) begin n_err++; $display("FAIL write_dropped_mret: got %h want 0", bus.csr_rdata); end
        set_csr(12'hB00, 2'd1, 64'h10); step();
        set_csr(12'hB00, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h10) begin n_err++; $display("FAIL mcycle_wr: got %h want 10", bus.csr_rdata); end
        step();
        set_csr(12'hB00, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h11) begin n_err++; $display("FAIL mcycle_inc: got %h want 11", bus.csr_rdata); end
        set_csr(12'hB00, 2'd1, '1); step();
        step();
        set_csr(12'hB00, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'd0) begin n_err++; $display("FAIL mcycle_wrap: got %h want 0", bus.csr_rdata); end
        bus.retire_valid = 1'b1;
        set_csr(12'hB02, 2'd1, 64'h20); step();
        bus.retire_valid = 1'b1;
        set_csr(12'hB02, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h20) begin n_err++; $display("FAIL minstret_wr: got %h want 20", bus.csr_rdata); end
        step(); step();
        set_csr(12'hB02, 2'd0, 64'd0);
        n_cmp++; if (bus.csr_rdata !== 64'h21) begin n_err++; $display("FAIL minstret_inc: got %h want 21", bus.csr_rdata); end
    endtask

    task automatic test_random();
        logic [11:0] pool [0:15];
        logic [11:0] a;
        logic [63:0] wd, exp_rd;
        logic [5:0]  exp_cause;
        logic        exp_ill;
        pool = '{12'h180, 12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                 12'h344, 12'hB00, 12'hB02, 12'hF14, 12'hB80, 12'h000, 12'h7C0, 12'h300};
        for (int i = 0; i < 400; i++) begin
            a  = pool[$urandom_range(15)];
            wd = {$urandom, $urandom};
            case ($urandom_range(3))
                0: wd = 64'd0;
                1: wd = wd & 64'h0000_0000_0000_1FFF;
                default: ;
            endcase
            bus.trap_valid   = ($urandom_range(15) == 0);
            bus.mret_valid   = ($urandom_range(15) == 0);
            bus.trap_is_irq  = 1'($urandom);
            bus.trap_cause   = 6'($urandom);
            bus.trap_pc      = {$urandom, $urandom};
            bus.trap_tval    = {$urandom, $urandom};
            bus.retire_valid = 1'($urandom);
            bus.ext_irq      = ($urandom_range(3) == 0);
            bus.timer_irq    = 1'($urandom);
            bus.sw_irq       = 1'($urandom);
            set_csr(a, 2'($urandom), wd);
            exp_ill   = m_illegal(a, bus.csr_op, wd);
            exp_rd    = exp_ill ? 64'd0 : m_csr[a];
            exp_cause = m_irq_cause();
            n_cmp++; if (bus.csr_rdata !== exp_rd || bus.csr_illegal !== exp_ill) begin n_err++; $display("FAIL rnd_read[%0d] addr %h op %0d: got %h/%b want %h/%b", i, a, bus.csr_op, bus.csr_rdata, bus.csr_illegal, exp_rd, exp_ill); end
            n_cmp++; if (bus.irq_cause !== exp_cause || bus.irq_pending !== (exp_cause != 6'd0)) begin n_err++; $display("FAIL rnd_irq[%0d]: got %b/%0d want %b/%0d", i, bus.irq_pending, bus.irq_cause, exp_cause != 6'd0, exp_cause); end
            n_cmp++; if (bus.priv_mode !== m_priv || bus.satp_out !== m_csr[12'h180]) begin n_err++; $display("FAIL rnd_state[%0d]: priv %b satp %h want %b %h", i, bus.priv_mode, bus.satp_out, m_priv, m_csr[12'h180]); end
            if (bus.trap_valid || bus.mret_valid) begin
                n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== m_redirect()) begin n_err++; $display("FAIL rnd_redirect[%0d]: got %b/%h want 1/%h", i, bus.redirect_valid, bus.redirect_pc, m_redirect()); end
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_mstatus();
        test_irq_trap();
        test_trap_mret();
        test_illegal();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/csr_file.md
# csr_file

Parametrised machine-mode CSR file for the RV core. It provides combinational CSR reads with privilege and legality checking and registered read-modify-write updates (CSRRW/CSRRS/CSRRC). It also handles trap entry, `mret` return and `mip` sampling, and runs the free-running `mcycle` and `minstret` counters. It sits beside the execute/commit stage and produces the redirect PC that commit needs for traps and returns.

## Interface
- `XLEN`, 64: register width; only 32 or 64 are legal.
- `MTVEC_RESET`, 0: reset value of `mtvec`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `csr_addr`  in  12  CSR address for the read and the write.
- `csr_op`  in  2  operation: 00 none, 01 RW, 10 RS (set bits), 11 RC (clear bits).
- `csr_wdata`  in  XLEN  write operand.
- `csr_rdata`  out  XLEN  current value of `csr_addr`; combinational.
- `csr_illegal`  out  1  access is illegal; combinational.
- `trap_valid`  in  1  take a trap this cycle.
- `trap_is_irq`  in  1  trap is an interrupt.
- `trap_cause`  in  6  exception or interrupt code.
- `trap_pc`  in  XLEN  PC of the trapping instruction.
- `trap_tval`  in  XLEN  value for `mtval`.
- `mret_valid`  in  1  execute `mret` this cycle.
- `retire_valid`  in  1  one instruction retires this cycle.
- `ext_irq`, `timer_irq`, `sw_irq`  in  1 each  raw interrupt lines.
- `redirect_valid`  out  1  equals `trap_valid | mret_valid`.
- `redirect_pc`  out  XLEN  fetch target for a trap or `mret`; combinational.
- `irq_pending`  out  1  an enabled interrupt is pending.
- `irq_cause`  out  6  code of the highest-priority pending interrupt.
- `priv_mode`  out  2  current privilege mode.
- `satp_out`  out  XLEN  current `satp`, for the MMU.

## Operation
Implemented CSRs and their write rules:
- `satp` (0x180): a write is accepted only if its MODE field is 0 or 8 (XLEN=64) or 0 or 1 (XLEN=32). Any other MODE drops the whole write.
- `mstatus` (0x300): only MIE[3], MPIE[7] and MPP[12:11] are writable; all other bits read 0. A write of MPP=10 stores 00.
- `mie` (0x304): bits 3, 7 and 11 are writable; the rest read 0.
- `mtvec` (0x305): the base is bits [XLEN-1:2]. A write of MODE ≥ 2 stores MODE 0.
- `mscratch` (0x340): fully writable.
- `mepc` (0x341): bits [1:0] always read 0.
- `mcause` (0x342) and `mtval` (0x343): fully writable.
- `mip` (0x344): read-only. Bit 3 = `sw_irq`, bit 7 = `timer_irq`, bit 11 = `ext_irq`, each registered every cycle.
- `mcycle` (0xB00) and `minstret` (0xB02): full width.
- `mcycleh` (0xB80) and `minstreth` (0xB82): exist only when XLEN=32 and map to the upper halves of the 64-bit counters.
- `mhartid` (0xF14): read-only, reads 0.

Legality and write rules:
- `csr_illegal` is 1 in any of these cases:
  - `csr_op`≠00 and the address is unimplemented.
  - `csr_addr[9:8]` is greater than `priv_mode`.
  - The access is a write to a read-only address (`csr_addr[11:10]`=11) or to `mip`.
- Illegal accesses read 0 and do not write.
- New value: RW gives `wdata`; RS gives `old | wdata`; RC gives `old & ~wdata`.
- RS or RC with `csr_wdata`=0 is a read only: no write occurs and it is never illegal for the read-only reason.
- `mcycle` increments every cycle. `minstret` increments when `retire_valid` is 1. A CSR write to either counter (or its high half) in the same cycle replaces that cycle's increment.

Trap entry (`trap_valid`):
- `mepc` ← `trap_pc` with bits [1:0] cleared.
- `mcause` ← bit XLEN-1 = `trap_is_irq`, low bits = `trap_cause`.
- `mtval` ← `trap_tval`.
- MPIE ← MIE, MIE ← 0, MPP ← `priv_mode`, `priv_mode` ← 11.
- `redirect_pc` is base + 4·cause when the trap is an interrupt and `mtvec` MODE=1; otherwise it is base.

`mret` (`mret_valid`):
- `priv_mode` ← MPP, MIE ← MPIE, MPIE ← 1, MPP ← 00.
- `redirect_pc` is the current `mepc`.

Interrupts:
- `irq_pending` = (MIE or `priv_mode`<11) and (`mip` & `mie`) is nonzero.
- Priority is MEI (11), then MSI (3), then MTI (7). `irq_cause` is 0 when nothing is pending.

## Timing
- Reads, `csr_illegal`, `redirect_*` and `irq_*` are combinational from current state. A write becomes visible after the next rising edge.
- `mip` lags the raw interrupt lines by 1 cycle.
- Priority when events coincide: trap over `mret`, and `mret` over a CSR write. The losing action is dropped entirely. The counters still increment.
- Reset values:
  - All CSRs 0, except `mtvec` = `MTVEC_RESET` and `priv_mode` = 11.
  - Counters 0.
  - Outputs follow from this state: `irq_pending` 0, `satp_out` 0.
- Reset asserted mid-operation clears state immediately and asynchronously. The first increment happens on the first edge after reset deasserts.
- Counters wrap from all-ones to 0 with no flag.

## Test plan
- Reset, then hold 5 idle edges → `mcycle` reads 5, `priv_mode`=11, `mtvec`=`MTVEC_RESET`.
- Write `mstatus` RW 0xFFFF_FFFF, then RC 0x8 → reads 0x1880, then 0x1880 with bit 3 cleared (0x1880 has bit 3 = 0, so it still reads 0x1880). Then RS 0x8 → 0x1888.
- `mtvec` = 0x1001 (vectored), `mie`[7]=1, MIE=1, raise `timer_irq` → `irq_pending`=1 after 1 cycle, `irq_cause`=7. A trap with cause 7 gives `redirect_pc`=0x101C, and MIE becomes 0.
- Trap at `trap_pc`=0x8000_0042 from mode 00, then `mret` → `mepc`=0x8000_0040, `redirect_pc`=0x8000_0040, `priv_mode` returns to 00.
- In mode 00, read 0x300 → `csr_illegal`=1, read 0. In mode 11, write 0xF14 → illegal and no change. Write `satp` with MODE 5 → ignored.
- Same-cycle trap and `mret`, and same-cycle write to `mcycle` with 0x10 → trap wins; `mcycle` reads 0x10 on the next cycle and 0x11 one cycle later.
